// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: NOP word, HALT opcode,
// opcode field bounds and the fetch FSM state encoding.
package mips_pkg;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  localparam logic [5:0]  HALT_OP   = 6'b111111;
  localparam int          OPCODE_HI = 31;
  localparam int          OPCODE_LO = 26;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // True when the opcode field of an instruction word equals op.
  function automatic logic opcode_is(input logic [31:0] word, input logic [5:0] op);
    return word[OPCODE_HI:OPCODE_LO] == op;
  endfunction

endpackage

// File: rtl/instruction_memory.sv
// Instruction memory: one synchronous write port for the loader and one
// combinational read port for fetch. Contents survive reset.
module instruction_memory #(
  parameter int NB_ADDR = 8,
  parameter int NB_DATA = 32
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [NB_ADDR-1:0] i_waddr,
  input  logic [NB_DATA-1:0] i_wdata,
  input  logic [NB_ADDR-1:0] i_raddr,
  output logic [NB_DATA-1:0] o_rdata
);

  logic [NB_DATA-1:0] mem_reg [2**NB_ADDR];

  // Loader write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      mem_reg[i_waddr] <= i_wdata;
    end
  end

  // Fetch sees the word at the current PC in the same cycle.
  assign o_rdata = mem_reg[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, the loadable instruction memory and the IF/ID
// register. Handles loader mode, stall/redirect requests and HALT.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int          NB_DATA     = 32,
  parameter int          NB_ADDR     = 8,
  parameter logic [5:0]  HALT_OPCODE = HALT_OP
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_load_we,
  input  logic [NB_ADDR-1:0] i_load_addr,
  input  logic [NB_DATA-1:0] i_load_data,
  input  logic               i_start,
  input  logic               i_stall,
  input  logic               i_jump,
  input  logic [NB_DATA-1:0] i_jump_addr,
  output logic [NB_DATA-1:0] o_instruction,
  output logic [NB_DATA-1:0] o_pcounter4,
  output logic [NB_DATA-1:0] o_pc,
  output logic               o_valid,
  output logic               o_halted
);

  localparam logic [NB_DATA-1:0] NOP      = NB_DATA'(NOP_WORD);
  localparam logic [NB_DATA-1:0] PC_STEP  = NB_DATA'(4);
  localparam logic [NB_DATA-1:0] WORD_MSK = ~NB_DATA'(3);

  fetch_state_e       state_reg, state_next;
  logic [NB_DATA-1:0] pc_reg, pc_next;
  logic [NB_DATA-1:0] instr_reg, instr_next;
  logic [NB_DATA-1:0] pc4_reg, pc4_next;
  logic               valid_reg, valid_next;
  logic [NB_DATA-1:0] fetch_word;
  logic               mem_we;

  // Memory is write-protected once fetching has started.
  assign mem_we = i_load_we && (state_reg == ST_LOAD);

  instruction_memory #(
    .NB_ADDR(NB_ADDR),
    .NB_DATA(NB_DATA)
  ) u_imem (
    .clk    (clk),
    .i_we   (mem_we),
    .i_waddr(i_load_addr),
    .i_wdata(i_load_data),
    .i_raddr(pc_reg[NB_ADDR+1:2]),
    .o_rdata(fetch_word)
  );

  // Next-state logic: redirect beats stall, stall beats fetch; a fetched
  // HALT word is latched into IF/ID but freezes the PC at its address.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    pc4_next   = pc4_reg;
    valid_next = valid_reg;
    case (state_reg)
      ST_LOAD: begin
        if (i_start) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_jump) begin
          pc_next    = i_jump_addr & WORD_MSK;
          instr_next = NOP;
          pc4_next   = NOP;
          valid_next = 1'b0;
        end else if (!i_stall) begin
          instr_next = fetch_word;
          pc4_next   = pc_reg + PC_STEP;
          valid_next = 1'b1;
          if (opcode_is(fetch_word, HALT_OPCODE)) begin
            state_next = ST_HALT;
          end else begin
            pc_next = pc_reg + PC_STEP;
          end
        end
      end
      ST_HALT: begin
        // The HALT word stays visible for the entry cycle only.
        instr_next = NOP;
        pc4_next   = NOP;
        valid_next = 1'b0;
      end
      default: begin
        state_next = ST_LOAD;
      end
    endcase
  end

  // State, PC and IF/ID register; reset overrides everything.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_reg <= ST_LOAD;
      pc_reg    <= '0;
      instr_reg <= NOP;
      pc4_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      pc4_reg   <= pc4_next;
      valid_reg <= valid_next;
    end
  end

  assign o_instruction = instr_reg;
  assign o_pcounter4   = pc4_reg;
  assign o_pc          = pc_reg;
  assign o_valid       = valid_reg;
  assign o_halted      = (state_reg == ST_HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed program scenarios
// followed by randomized traffic, all compared against a cycle model.
module tb_instruction_fetch;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 8;
  localparam int MEM_WORDS = 2**NB_ADDR;

  logic               clk = 1'b0;
  logic               rst;
  logic               load_we;
  logic [NB_ADDR-1:0] load_addr;
  logic [NB_DATA-1:0] load_data;
  logic               start;
  logic               stall;
  logic               jump;
  logic [NB_DATA-1:0] jump_addr;
  logic [NB_DATA-1:0] instruction, pcounter4, pc;
  logic               valid, halted;

  int checks = 0;
  int errors = 0;

  // Reference model: memory image plus architectural view of the stage.
  logic [31:0] m_mem [MEM_WORDS];
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_mode; // 0 = loading, 1 = running, 2 = halted

  always #5 clk = ~clk;

  instruction_fetch #(
    .NB_DATA(NB_DATA),
    .NB_ADDR(NB_ADDR),
    .HALT_OPCODE(6'b111111)
  ) dut (
    .clk          (clk),
    .i_rst        (rst),
    .i_load_we    (load_we),
    .i_load_addr  (load_addr),
    .i_load_data  (load_data),
    .i_start      (start),
    .i_stall      (stall),
    .i_jump       (jump),
    .i_jump_addr  (jump_addr),
    .o_instruction(instruction),
    .o_pcounter4  (pcounter4),
    .o_pc         (pc),
    .o_valid      (valid),
    .o_halted     (halted)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    rst = 0; load_we = 0; load_addr = '0; load_data = '0;
    start = 0; stall = 0; jump = 0; jump_addr = '0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [31:0] w;
    if (rst) begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_mode = 0;
    end else if (m_mode == 0) begin
      if (load_we) m_mem[load_addr] = load_data;
      if (start) m_mode = 1;
    end else if (m_mode == 1) begin
      if (jump) begin
        m_pc = (jump_addr / 4) * 4;
        m_instr = 0; m_pc4 = 0; m_valid = 0;
      end else if (!stall) begin
        w = m_mem[(m_pc / 4) % MEM_WORDS];
        m_instr = w;
        m_pc4 = m_pc + 4;
        m_valid = 1;
        if ((w >> 26) == 63) m_mode = 2;
        else m_pc = m_pc + 4;
      end
    end else begin
      m_instr = 0; m_pc4 = 0; m_valid = 0;
    end
  endtask

  // One clock: update model, let the edge pass, compare every output.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_value("pc", pc, m_pc);
    check_value("instruction", instruction, m_instr);
    if (m_valid || m_mode == 0) check_value("pcounter4", pcounter4, m_pc4);
    check_value("valid", {31'b0, valid}, {31'b0, m_valid});
    check_value("halted", {31'b0, halted}, {31'b0, (m_mode == 2)});
    $display("cyc pc=%h instr=%h pc4=%h valid=%0b halted=%0b", pc, instruction, pcounter4, valid, halted);
  endtask

  task automatic restart();
    rst = 1; cycle(); rst = 0;
    start = 1; cycle(); start = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1; cycle(); cycle(); rst = 0;
    check_value("reset_pc", pc, 32'h0);
    check_value("reset_instr", instruction, 32'h0);
    check_value("reset_valid", {31'b0, valid}, 32'h0);

    // Fill the whole memory with non-HALT words, then the program.
    for (int a = 0; a < MEM_WORDS; a++) begin
      load_we = 1; load_addr = NB_ADDR'(a);
      load_data = $urandom & 32'h7FFF_FFFF;
      if (a == 0) load_data = 32'h2001_0005;
      if (a == 1) load_data = 32'h2002_0007;
      if (a == 2) load_data = 32'hFC00_0000;
      if (a == 7) load_data = 32'h2003_0009;
      cycle();
      check_value("load_pc_idle", pc, 32'h0);
    end
    load_we = 0;

    // Straight-line program ending in HALT.
    start = 1; cycle(); start = 0;
    cycle();
    check_value("prog_i0", instruction, 32'h2001_0005);
    check_value("prog_p0", pcounter4, 32'd4);
    cycle();
    check_value("prog_i1", instruction, 32'h2002_0007);
    check_value("prog_p1", pcounter4, 32'd8);
    cycle();
    check_value("prog_i2", instruction, 32'hFC00_0000);
    check_value("prog_p2", pcounter4, 32'd12);
    check_value("prog_halt", {31'b0, halted}, 32'd1);
    check_value("prog_halt_pc", pc, 32'd8);
    cycle();
    check_value("halt_valid", {31'b0, valid}, 32'd0);
    jump = 1; jump_addr = 32'h40; start = 1; load_we = 1; load_addr = '0; load_data = 32'h0;
    cycle();
    idle_inputs();
    check_value("halt_ignore_pc", pc, 32'd8);

    // Three-cycle stall at pc=4.
    restart(); cycle();
    for (int k = 0; k < 3; k++) begin
      stall = 1; cycle();
      check_value("stall_instr", instruction, 32'h2001_0005);
      check_value("stall_pc4", pcounter4, 32'd4);
      check_value("stall_pc", pc, 32'd4);
    end
    stall = 0; cycle();
    check_value("stall_resume", instruction, 32'h2002_0007);

    // Redirect to an unaligned target, then wrap at the top of PC space.
    restart(); cycle();
    jump = 1; jump_addr = 32'h1E; cycle(); jump = 0;
    check_value("jump_pc", pc, 32'h1C);
    check_value("jump_nop", instruction, 32'h0);
    cycle();
    check_value("jump_fetch", instruction, 32'h2003_0009);
    check_value("jump_next_pc", pc, 32'h20);
    jump = 1; jump_addr = 32'hFFFF_FFFE; cycle(); jump = 0;
    check_value("wrap_jump_pc", pc, 32'hFFFF_FFFC);
    cycle();
    check_value("wrap_pc", pc, 32'h0);
    check_value("wrap_pc4", pcounter4, 32'h0);
    check_value("wrap_instr", instruction, m_mem[MEM_WORDS-1]);

    // Jump and stall together: jump wins.
    restart(); cycle(); cycle();
    jump = 1; stall = 1; jump_addr = 32'h40; cycle(); jump = 0; stall = 0;
    check_value("jstall_pc", pc, 32'h40);
    check_value("jstall_instr", instruction, 32'h0);

    // HALT word at PC while jumping: wrong path, no halt.
    restart(); cycle(); cycle();
    jump = 1; jump_addr = 32'h0; cycle(); jump = 0;
    check_value("hjump_halted", {31'b0, halted}, 32'd0);
    check_value("hjump_pc", pc, 32'h0);

    // HALT word under stall: halt only after release.
    restart(); cycle(); cycle();
    stall = 1; cycle(); cycle();
    check_value("hstall_halted", {31'b0, halted}, 32'd0);
    stall = 0; cycle();
    check_value("hstall_release", {31'b0, halted}, 32'd1);
    check_value("hstall_instr", instruction, 32'hFC00_0000);

    // Reset mid-run at pc=0x10, then loader writes during RUN.
    restart(); cycle();
    jump = 1; jump_addr = 32'h0C; cycle(); jump = 0;
    cycle();
    check_value("mid_pc", pc, 32'h10);
    rst = 1; cycle(); rst = 0;
    check_value("mid_rst_pc", pc, 32'h0);
    check_value("mid_rst_instr", instruction, 32'h0);
    check_value("mid_rst_valid", {31'b0, valid}, 32'd0);
    start = 1; cycle(); start = 0;
    load_we = 1; load_addr = 8'd1; load_data = 32'hDEAD_BEEF; cycle(); load_we = 0;
    check_value("rerun_i0", instruction, 32'h2001_0005);
    cycle();
    check_value("protect_i1", instruction, 32'h2002_0007);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 99) < 2);
      start     = ($urandom_range(0, 99) < 20);
      load_we   = ($urandom_range(0, 99) < 30);
      load_addr = NB_ADDR'($urandom);
      load_data = $urandom;
      stall     = ($urandom_range(0, 99) < 20);
      jump      = ($urandom_range(0, 99) < 10);
      jump_addr = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'h3FF);
      cycle();
    end
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
